// File: rtl/signed_mul_if.sv
// Handshake and operand/result bundle for the sequential signed multiplier.
//   start   : request a multiply (taken only while ready is high)
//   word1   : N-bit signed multiplicand
//   word2   : M-bit signed multiplier
//   product : (N+M)-bit signed product, holds the last completed result
//   ready   : 1 = idle and product valid, 0 = busy
// master drives the request side, slave is the multiplier.
interface signed_mul_if #(
    parameter int unsigned N = 8,
    parameter int unsigned M = 4
);
    logic             start;
    logic [N-1:0]     word1;
    logic [M-1:0]     word2;
    logic [N+M-1:0]   product;
    logic             ready;

    modport master (
        output start,
        output word1,
        output word2,
        input  product,
        input  ready
    );

    modport slave (
        input  start,
        input  word1,
        input  word2,
        output product,
        output ready
    );
endinterface

// File: rtl/signed_mul.sv
// Sequential radix-2 Booth signed multiplier, one multiplier bit per clock.
// Shares the start/ready handshake of the signed divider so both can sit in
// the same multi-cycle ALU slot.
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-low reset
//   bus   : signed_mul_if slave (start, word1, word2, product, ready)
// Parameters: N multiplicand width, M multiplier width (= step count),
// L counter width with 2^L > M.
module signed_mul #(
    parameter int unsigned N = 8,
    parameter int unsigned M = 4,
    parameter int unsigned L = 3
) (
    input  logic         clk,
    input  logic         reset,
    signed_mul_if.slave  bus
);
    // One guard bit on the accumulator keeps -2^(N-1) * anything exact.
    localparam int unsigned AW = N + 1;
    localparam int unsigned PW = N + M;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state, state_n;
    logic [AW-1:0]  acc, acc_n;
    logic [AW-1:0]  mcand, mcand_n;
    logic [M-1:0]   q, q_n;
    logic           qm1, qm1_n;
    logic [L-1:0]   cnt, cnt_n;
    logic [PW-1:0]  prod, prod_n;
    logic           rdy;
    logic [AW-1:0]  sum_c;

    // Next-state, Booth step and result capture.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        mcand_n = mcand;
        q_n     = q;
        qm1_n   = qm1;
        cnt_n   = cnt;
        prod_n  = prod;
        sum_c   = acc;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_n   = '0;
                    mcand_n = {bus.word1[N-1], bus.word1};
                    q_n     = bus.word2;
                    qm1_n   = 1'b0;
                    cnt_n   = L'(M);
                    state_n = RUN;
                end
            end
            RUN: begin
                // Booth recoding of {Q[0], q-1}.
                case ({q[0], qm1})
                    2'b01:   sum_c = acc + mcand;
                    2'b10:   sum_c = acc - mcand;
                    default: sum_c = acc;
                endcase
                // Arithmetic shift of {A, Q, q-1} right by one.
                acc_n = {sum_c[AW-1], sum_c[AW-1:1]};
                q_n   = {sum_c[0], q[M-1:1]};
                qm1_n = q[0];
                cnt_n = cnt - L'(1);
                if (cnt == L'(1)) begin
                    prod_n  = {acc_n[N-1:0], q_n};
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers; ready tracks the IDLE state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            acc   <= '0;
            mcand <= '0;
            q     <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            prod  <= '0;
            rdy   <= 1'b1;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            mcand <= mcand_n;
            q     <= q_n;
            qm1   <= qm1_n;
            cnt   <= cnt_n;
            prod  <= prod_n;
            rdy   <= (state_n == IDLE);
        end
    end

    assign bus.product = prod;
    assign bus.ready   = rdy;
endmodule

// File: tb/tb_signed_mul.sv
// Self-checking bench for signed_mul: a driver issues requests and pushes the
// arithmetic product into a scoreboard; a monitor pops on every completion
// and also checks reset behaviour, busy length and product stability.
module tb_signed_mul;
    localparam int unsigned N  = 8;
    localparam int unsigned M  = 4;
    localparam int unsigned L  = 3;
    localparam int unsigned PW = N + M;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    signed_mul_if #(.N(N), .M(M)) bus ();

    signed_mul #(.N(N), .M(M), .L(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [PW-1:0] sb_q[$];

    // Reset level as seen by the DUT at the most recent rising edge.
    logic rst_seen = 1'b1;
    always @(posedge clk) rst_seen <= reset;

    // Reference: plain signed arithmetic, truncated to the product width.
    function automatic logic [PW-1:0] ref_mul(input logic [N-1:0] a, input logic [M-1:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return PW'(pa * pb);
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor state.
    logic          prev_ready;
    logic [PW-1:0] hold;
    logic [PW-1:0] exp_p;
    int            busy;

    initial begin : monitor
        prev_ready = 1'b1;
        hold       = '0;
        busy       = 0;
        forever begin
            @(negedge clk);
            if (!rst_seen) begin
                chk("reset_ready", PW'(bus.ready), PW'(1));
                chk("reset_product", bus.product, '0);
                sb_q.delete();
                hold = '0;
                busy = 0;
            end else if (bus.ready && !prev_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: product %h with nothing pending (cycle %0d)",
                             bus.product, cyc);
                end else begin
                    exp_p = sb_q.pop_front();
                    chk("product", bus.product, exp_p);
                    chk("busy_cycles", PW'(busy), PW'(M));
                    hold = exp_p;
                end
                busy = 0;
            end else begin
                if (!bus.ready) busy++;
                chk("product_hold", bus.product, hold);
            end
            prev_ready = bus.ready;
        end
    end

    // Raise start with operands; wait for the accepting edge; push expectation.
    task automatic issue(input logic [N-1:0] a, input logic [M-1:0] b, output int acc_cyc);
        bit ok;
        ok        = 1'b0;
        bus.start = 1'b1;
        bus.word1 = a;
        bus.word2 = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready never high, got 0 required 1");
        end else begin
            sb_q.push_back(ref_mul(a, b));
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.word1 = N'($urandom);
        bus.word2 = M'($urandom);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && bus.ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: pending=%0d ready=%b required pending=0 ready=1",
                     sb_q.size(), bus.ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int c1;
        int c2;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.word1 = '0;
        bus.word2 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        gap(1);

        // Basic signs and extremes.
        issue(8'd7,    4'd3,  c1); wait_idle();
        issue(8'hFB,   4'd3,  c1); wait_idle();
        issue(8'd5,    4'hF,  c1); wait_idle();
        issue(8'h80,   4'h8,  c1); wait_idle();
        issue(8'h7F,   4'h8,  c1); wait_idle();
        issue(8'h00,   4'h8,  c1); wait_idle();
        issue(8'h80,   4'h7,  c1); wait_idle();

        // Start while busy is ignored.
        issue(8'd7, 4'd3, c1);
        bus.start = 1'b1;
        bus.word1 = 8'd9;
        bus.word2 = 4'd2;
        gap(1);
        bus.start = 1'b0;
        wait_idle();

        // Reset on the second RUN cycle aborts, then a normal op.
        issue(8'hFB, 4'd3, c1);
        gap(1);
        reset = 1'b0;
        gap(1);
        reset = 1'b1;
        issue(8'd2, 4'd2, c1); wait_idle();

        // Reset and start together: reset wins, nothing starts.
        reset     = 1'b0;
        bus.start = 1'b1;
        bus.word1 = 8'd3;
        bus.word2 = 4'd5;
        gap(1);
        reset     = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("no_start_under_reset", PW'(bus.ready), PW'(1));
        gap(2);

        // Back-to-back: second accepted in the first ready cycle.
        issue(8'd7, 4'd3, c1);
        issue(8'd3, 4'd3, c2);
        chk("b2b_spacing", PW'(c2 - c1), PW'(M + 1));
        wait_idle();

        // Randomized operands and idle gaps.
        for (int i = 0; i < 150; i++) begin
            issue(N'($urandom), M'($urandom), c1);
            if ($urandom_range(0, 3) == 0) wait_idle();
            else gap($urandom_range(0, 2));
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
